// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the execute stage and a simple
// req/ack memory port. It handles sub-word loads (sign/zero extension),
// sub-word stores (read-modify-write), ALU result pass-through, and the
// register write-back.
// Optional build macro MISALIGN_TRAP_EN adds misalign_o. With the macro,
// misaligned half/word accesses trap. Without it, they are aligned down.

`ifndef DATA_TYPE_BUS
`define DATA_TYPE_BUS 2:0
`endif
`ifndef DATATYPE_BYTE
`define DATATYPE_BYTE 3'd0
`endif
`ifndef DATATYPE_HALF
`define DATATYPE_HALF 3'd1
`endif
`ifndef DATATYPE_WORD
`define DATATYPE_WORD 3'd2
`endif
`ifndef DATATYPE_UBYTE
`define DATATYPE_UBYTE 3'd3
`endif
`ifndef DATATYPE_UHALF
`define DATATYPE_UHALF 3'd4
`endif
`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif

module mem_access_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned LANE_W = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  ld_i,
    input  logic                  st_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [`DATA_TYPE_BUS] data_type_i,
    input  logic [`REG_ADDR_BUS]  w_reg_addr_i,
    input  logic                  ex_w_reg_enable_i,
    input  logic [DATA_W-1:0]     ex_w_reg_data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  w_reg_enable_o,
    output logic [`REG_ADDR_BUS]  w_reg_addr_o,
    output logic [DATA_W-1:0]     w_reg_data_o,
    output logic                  busy_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

    state_t                 state_q, state_d;
    logic [LANE_W-1:0]      off_q, off_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [`DATA_TYPE_BUS]  type_q, type_d;
    logic [`REG_ADDR_BUS]   rd_q, rd_d;
    logic                   st_q, st_d;

    logic                   req_d, we_d, wen_d;
    logic [ADDR_W-1:0]      maddr_d;
    logic [DATA_W-1:0]      mwdata_d, wdat_d;
    logic [`REG_ADDR_BUS]   wrd_d;
`ifdef MISALIGN_TRAP_EN
    logic                   mis_d;
`endif

    // Byte, ubyte, half and uhalf are the sub-word types. Any other code is treated as a full word.
    function automatic logic is_sub(input logic [`DATA_TYPE_BUS] t);
        case (t)
            `DATATYPE_BYTE, `DATATYPE_UBYTE,
            `DATATYPE_HALF, `DATATYPE_UHALF: is_sub = 1'b1;
            default:                         is_sub = 1'b0;
        endcase
    endfunction

    // Effective lane offset. Half accesses are aligned down to 2 bytes, and words to 0.
    function automatic logic [LANE_W-1:0] lane_off(input logic [LANE_W-1:0] a,
                                                   input logic [`DATA_TYPE_BUS] t);
        case (t)
            `DATATYPE_BYTE, `DATATYPE_UBYTE: lane_off = a;
            `DATATYPE_HALF, `DATATYPE_UHALF: lane_off = a & ~LANE_W'(1);
            default:                         lane_off = '0;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    // An access is misaligned when it is not on its natural boundary.
    function automatic logic misaligned(input logic [LANE_W-1:0] a,
                                        input logic [`DATA_TYPE_BUS] t);
        case (t)
            `DATATYPE_BYTE, `DATATYPE_UBYTE: misaligned = 1'b0;
            `DATATYPE_HALF, `DATATYPE_UHALF: misaligned = a[0];
            default:                         misaligned = (a != '0);
        endcase
    endfunction
`endif

    // Select the addressed lane of a read word and extend it to DATA_W.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                  input logic [LANE_W-1:0] off,
                                                  input logic [`DATA_TYPE_BUS] t);
        logic [DATA_W-1:0] sh;
        sh = w >> {off, 3'b000};
        case (t)
            `DATATYPE_BYTE:  extract = {{(DATA_W-8){sh[7]}}, sh[7:0]};
            `DATATYPE_UBYTE: extract = {{(DATA_W-8){1'b0}}, sh[7:0]};
            `DATATYPE_HALF:  extract = {{(DATA_W-16){sh[15]}}, sh[15:0]};
            `DATATYPE_UHALF: extract = {{(DATA_W-16){1'b0}}, sh[15:0]};
            default:         extract = sh;
        endcase
    endfunction

    // Merge the low bits of the store data into the addressed lane of the old word.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [LANE_W-1:0] off,
                                                input logic [`DATA_TYPE_BUS] t);
        logic [DATA_W-1:0] mask;
        case (t)
            `DATATYPE_BYTE, `DATATYPE_UBYTE: mask = DATA_W'(8'hFF) << {off, 3'b000};
            `DATATYPE_HALF, `DATATYPE_UHALF: mask = DATA_W'(16'hFFFF) << {off, 3'b000};
            default:                         mask = '1;
        endcase
        merge = (old & ~mask) | ((wd << {off, 3'b000}) & mask);
    endfunction

    assign ready_o = (state_q == IDLE) && !rst;
    assign busy_o  = !ready_o;

    // Next-state and next-output logic for the request/memory/write-back sequencing.
    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        type_d   = type_q;
        rd_d     = rd_q;
        st_d     = st_q;
        req_d    = mem_req_o;
        we_d     = mem_we_o;
        maddr_d  = mem_addr_o;
        mwdata_d = mem_wdata_o;
        wen_d    = 1'b0;
        wrd_d    = w_reg_addr_o;
        wdat_d   = w_reg_data_o;
`ifdef MISALIGN_TRAP_EN
        mis_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (valid_i && ready_o) begin
                    off_d   = lane_off(addr_i[LANE_W-1:0], data_type_i);
                    wdata_d = wdata_i;
                    type_d  = data_type_i;
                    rd_d    = w_reg_addr_i;
                    st_d    = st_i && !ld_i;
                    if (!(ld_i || st_i)) begin
                        wen_d  = ex_w_reg_enable_i && (w_reg_addr_i != '0);
                        wrd_d  = w_reg_addr_i;
                        wdat_d = ex_w_reg_data_i;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (misaligned(addr_i[LANE_W-1:0], data_type_i)) begin
                        mis_d = 1'b1;
                    end
`endif
                    else begin
                        req_d   = 1'b1;
                        maddr_d = {addr_i[ADDR_W-1:LANE_W], LANE_W'(0)};
                        if (st_i && !ld_i && !is_sub(data_type_i)) begin
                            state_d  = WR;
                            we_d     = 1'b1;
                            mwdata_d = wdata_i;
                        end else begin
                            state_d = RD;
                            we_d    = 1'b0;
                        end
                    end
                end
            end
            RD: begin
                if (mem_ack_i) begin
                    if (st_q) begin
                        state_d  = WR;
                        we_d     = 1'b1;
                        mwdata_d = merge(mem_rdata_i, wdata_q, off_q, type_q);
                    end else begin
                        state_d = WB;
                        req_d   = 1'b0;
                        wen_d   = (rd_q != '0);
                        wrd_d   = rd_q;
                        wdat_d  = extract(mem_rdata_i, off_q, type_q);
                    end
                end
            end
            WR: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs. Reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            off_q          <= '0;
            wdata_q        <= '0;
            type_q         <= '0;
            rd_q           <= '0;
            st_q           <= 1'b0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            w_reg_enable_o <= 1'b0;
            w_reg_addr_o   <= '0;
            w_reg_data_o   <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_o     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            off_q          <= off_d;
            wdata_q        <= wdata_d;
            type_q         <= type_d;
            rd_q           <= rd_d;
            st_q           <= st_d;
            mem_req_o      <= req_d;
            mem_we_o       <= we_d;
            mem_addr_o     <= maddr_d;
            mem_wdata_o    <= mwdata_d;
            w_reg_enable_o <= wen_d;
            w_reg_addr_o   <= wrd_d;
            w_reg_data_o   <= wdat_d;
`ifdef MISALIGN_TRAP_EN
            misalign_o     <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit (DATA_W = 32). It runs directed cases, then
// random traffic, and checks every cycle against a transaction-level model.
// Under MISALIGN_TRAP_EN it also checks misalign_o.

module tb_mem_access_unit;

    localparam logic [2:0] DT_BYTE  = 3'd0;
    localparam logic [2:0] DT_HALF  = 3'd1;
    localparam logic [2:0] DT_WORD  = 3'd2;
    localparam logic [2:0] DT_UBYTE = 3'd3;
    localparam logic [2:0] DT_UHALF = 3'd4;
`ifdef MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, ld_i, st_i;
    logic [31:0] addr_i, wdata_i;
    logic [2:0]  data_type_i;
    logic [4:0]  w_reg_addr_i;
    logic        ex_w_reg_enable_i;
    logic [31:0] ex_w_reg_data_i;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        w_reg_enable_o;
    logic [4:0]  w_reg_addr_o;
    logic [31:0] w_reg_data_o;
    logic        busy_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk               (clk),
        .rst               (rst),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .ld_i              (ld_i),
        .st_i              (st_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .data_type_i       (data_type_i),
        .w_reg_addr_i      (w_reg_addr_i),
        .ex_w_reg_enable_i (ex_w_reg_enable_i),
        .ex_w_reg_data_i   (ex_w_reg_data_i),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_ack_i         (mem_ack_i),
        .mem_rdata_i       (mem_rdata_i),
        .w_reg_enable_o    (w_reg_enable_o),
        .w_reg_addr_o      (w_reg_addr_o),
        .w_reg_data_o      (w_reg_data_o),
        .busy_o            (busy_o)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_o        (misalign_o)
`endif
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  dt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        ex_en;
        logic [31:0] ex_data;
        int          ack_delay;
        bit          rst_in_rd;
        bit          lit_wb_v;
        logic [31:0] lit_wb;
        bit          lit_addr_v;
        logic [31:0] lit_addr;
        bit          lit_mw_v;
        logic [31:0] lit_mw;
    } txn_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    txn_t        script[$];
    txn_t        cur;
    int          n_rand_left;
    logic [31:0] mem [logic [31:0]];

    // Transaction-level model of what the outputs must be
    bit          m_req, m_we, m_wen, m_cool, m_mis;
    logic [31:0] m_addr, m_mwdata, m_wdat;
    logic [4:0]  m_wrd;
    int          ack_cnt;
    bit          rst_late_ack;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h9E37_79B1;
    endfunction

    function automatic bit is_sub(input logic [2:0] t);
        return (t == DT_BYTE) || (t == DT_UBYTE) || (t == DT_HALF) || (t == DT_UHALF);
    endfunction

    function automatic bit misal(input logic [31:0] a, input logic [2:0] t);
        if (t == DT_BYTE || t == DT_UBYTE) return 1'b0;
        if (t == DT_HALF || t == DT_UHALF) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    // Load value: pick the byte/halfword arithmetically and apply two's-complement sign.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] t);
        int unsigned b;
        logic [31:0] v;
        if (t == DT_BYTE || t == DT_UBYTE) begin
            b = a % 4;
            v = (w >> (8 * b)) & 32'hFF;
            if (t == DT_BYTE && v >= 32'h80) v = v - 32'h100;
        end else if (t == DT_HALF || t == DT_UHALF) begin
            b = ((a % 4) / 2) * 2;
            v = (w >> (8 * b)) & 32'hFFFF;
            if (t == DT_HALF && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [2:0] t);
        int unsigned s;
        if (t == DT_BYTE || t == DT_UBYTE) begin
            s = 8 * (a % 4);
            return (old & ~(32'hFF << s)) | ((wd & 32'hFF) << s);
        end else if (t == DT_HALF || t == DT_UHALF) begin
            s = 8 * (((a % 4) / 2) * 2);
            return (old & ~(32'hFFFF << s)) | ((wd & 32'hFFFF) << s);
        end
        return wd;
    endfunction

    function automatic txn_t mk(input logic ld, input logic st, input logic [2:0] dt,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic ex_en,
                                input logic [31:0] ex_data, input int dly);
        txn_t t;
        t.ld = ld; t.st = st; t.dt = dt; t.addr = addr; t.wdata = wdata; t.rd = rd;
        t.ex_en = ex_en; t.ex_data = ex_data; t.ack_delay = dly; t.rst_in_rd = 1'b0;
        t.lit_wb_v = 1'b0; t.lit_wb = '0; t.lit_addr_v = 1'b0; t.lit_addr = '0;
        t.lit_mw_v = 1'b0; t.lit_mw = '0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int k;
        k = int'($urandom_range(0, 3));
        return mk(k == 1 || k == 3, k == 2 || k == 3, 3'($urandom_range(0, 4)),
                  32'h100 + 32'($urandom_range(0, 63)), $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)));
    endfunction

    // Drive memory responder, reset and request inputs for the coming edge.
    task automatic drive();
        rst = 1'b0;
        if (rst_late_ack) begin
            mem_ack_i    = 1'b1;
            mem_rdata_i  = 32'hCAFE_F00D;
            rst_late_ack = 1'b0;
        end else if (m_req && cur.rst_in_rd && !m_we) begin
            rst           = 1'b1;
            mem_ack_i     = 1'b0;
            rst_late_ack  = 1'b1;
            cur.rst_in_rd = 1'b0;
        end else if (m_req) begin
            mem_ack_i   = (ack_cnt >= cur.ack_delay);
            mem_rdata_i = m_we ? $urandom : mem_rd(m_addr);
        end else begin
            mem_ack_i   = ($urandom_range(0, 7) == 0);
            mem_rdata_i = $urandom;
        end
        if (script.size() == 0 && n_rand_left > 0) begin
            script.push_back(rand_txn());
            n_rand_left--;
        end
        if (script.size() > 0 && !rst && $urandom_range(0, 3) != 0) begin
            valid_i           = 1'b1;
            ld_i              = script[0].ld;
            st_i              = script[0].st;
            data_type_i       = script[0].dt;
            addr_i            = script[0].addr;
            wdata_i           = script[0].wdata;
            w_reg_addr_i      = script[0].rd;
            ex_w_reg_enable_i = script[0].ex_en;
            ex_w_reg_data_i   = script[0].ex_data;
        end else begin
            valid_i           = 1'b0;
            ld_i              = 1'($urandom_range(0, 1));
            st_i              = 1'($urandom_range(0, 1));
            addr_i            = $urandom;
            w_reg_addr_i      = 5'($urandom_range(0, 31));
            ex_w_reg_enable_i = 1'b1;
        end
    endtask

    // Advance the model across one rising edge using the inputs just driven.
    task automatic model_edge();
        bit n_wen, n_cool, n_mis;
        n_wen = 1'b0; n_cool = 1'b0; n_mis = 1'b0;
        if (rst) begin
            m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_mwdata = '0;
            m_wrd = '0; m_wdat = '0; ack_cnt = 0;
        end else if (m_req) begin
            if (mem_ack_i) begin
                ack_cnt = 0;
                if (!m_we && cur.ld) begin
                    m_req  = 1'b0;
                    n_wen  = (cur.rd != 5'd0);
                    m_wrd  = cur.rd;
                    m_wdat = ref_load(mem_rdata_i, cur.addr, cur.dt);
                    n_cool = 1'b1;
                end else if (!m_we) begin
                    m_we     = 1'b1;
                    m_mwdata = ref_merge(mem_rdata_i, cur.wdata, cur.addr, cur.dt);
                end else begin
                    mem[m_addr] = m_mwdata;
                    m_req = 1'b0;
                    m_we  = 1'b0;
                end
            end else begin
                ack_cnt++;
            end
        end else if (!m_cool && valid_i) begin
            cur = script.pop_front();
            ack_cnt = 0;
            if (!cur.ld && !cur.st) begin
                n_wen  = cur.ex_en && (cur.rd != 5'd0);
                m_wrd  = cur.rd;
                m_wdat = cur.ex_data;
            end else if (MIS_EN && misal(cur.addr, cur.dt)) begin
                n_mis = 1'b1;
            end else begin
                m_req  = 1'b1;
                m_addr = cur.addr & ~32'h3;
                if (!cur.ld && !is_sub(cur.dt)) begin
                    m_we     = 1'b1;
                    m_mwdata = cur.wdata;
                end else begin
                    m_we = 1'b0;
                end
            end
        end
        m_wen  = n_wen;
        m_cool = n_cool;
        m_mis  = n_mis;
    endtask

    task automatic check();
        cmp("busy_vs_ready", 32'(busy_o), 32'(!ready_o));
        cmp("ready", 32'(ready_o), 32'(!m_req && !m_cool && !rst));
        cmp("mem_req", 32'(mem_req_o), 32'(m_req));
        if (m_req) begin
            cmp("mem_addr", mem_addr_o, m_addr);
            cmp("mem_we", 32'(mem_we_o), 32'(m_we));
            if (m_we) cmp("mem_wdata", mem_wdata_o, m_mwdata);
            if (cur.lit_addr_v) cmp("lit_mem_addr", mem_addr_o, cur.lit_addr);
            if (m_we && cur.lit_mw_v) cmp("lit_mem_wdata", mem_wdata_o, cur.lit_mw);
        end
        cmp("w_reg_enable", 32'(w_reg_enable_o), 32'(m_wen));
        if (m_wen) begin
            cmp("w_reg_addr", 32'(w_reg_addr_o), 32'(m_wrd));
            cmp("w_reg_data", w_reg_data_o, m_wdat);
            if (cur.lit_wb_v) cmp("lit_wb_data", w_reg_data_o, cur.lit_wb);
        end
`ifdef MISALIGN_TRAP_EN
        cmp("misalign", 32'(misalign_o), 32'(m_mis));
`endif
    endtask

    initial begin
        txn_t t;
        int   cyc;
        rst = 1'b1; valid_i = 1'b0; ld_i = 1'b0; st_i = 1'b0; addr_i = '0; wdata_i = '0;
        data_type_i = DT_WORD; w_reg_addr_i = '0; ex_w_reg_enable_i = 1'b0;
        ex_w_reg_data_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        m_req = 0; m_we = 0; m_wen = 0; m_cool = 0; m_mis = 0; m_addr = '0; m_mwdata = '0;
        m_wdat = '0; m_wrd = '0; ack_cnt = 0; rst_late_ack = 0;
        cur = mk(0, 0, DT_WORD, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_mem_req", 32'(mem_req_o), 32'd0);
        cmp("rst_mem_we", 32'(mem_we_o), 32'd0);
        cmp("rst_w_reg_enable", 32'(w_reg_enable_o), 32'd0);
        cmp("rst_mem_addr", mem_addr_o, 32'd0);
        cmp("rst_mem_wdata", mem_wdata_o, 32'd0);
        cmp("rst_w_reg_data", w_reg_data_o, 32'd0);
        cmp("rst_w_reg_addr", 32'(w_reg_addr_o), 32'd0);
        cmp("rst_ready_low", 32'(ready_o), 32'd0);
        cmp("rst_busy_high", 32'(busy_o), 32'd1);
`ifdef MISALIGN_TRAP_EN
        cmp("rst_misalign", 32'(misalign_o), 32'd0);
`endif

        mem[32'h1000] = 32'h80FF_1234;
        mem[32'h2000] = 32'h1122_3344;
        t = mk(1, 0, DT_BYTE, 32'h1003, 0, 5'd7, 0, 0, 2);
        t.lit_wb_v = 1; t.lit_wb = 32'hFFFF_FF80; t.lit_addr_v = 1; t.lit_addr = 32'h1000;
        script.push_back(t);
        t = mk(1, 0, DT_UBYTE, 32'h1003, 0, 5'd8, 0, 0, 1);
        t.lit_wb_v = 1; t.lit_wb = 32'h0000_0080;
        script.push_back(t);
        t = mk(1, 0, DT_UHALF, 32'h1002, 0, 5'd9, 0, 0, 0);
        t.lit_wb_v = 1; t.lit_wb = 32'h0000_80FF;
        script.push_back(t);
        t = mk(0, 1, DT_BYTE, 32'h2001, 32'hFFFF_FFAB, 5'd3, 1, 0, 1);
        t.lit_addr_v = 1; t.lit_addr = 32'h2000; t.lit_mw_v = 1; t.lit_mw = 32'h1122_AB44;
        script.push_back(t);
        t = mk(0, 0, DT_WORD, 0, 0, 5'd5, 1, 32'hDEAD_BEEF, 0);
        t.lit_wb_v = 1; t.lit_wb = 32'hDEAD_BEEF;
        script.push_back(t);
        script.push_back(mk(0, 0, DT_WORD, 0, 0, 5'd0, 1, 32'h1234_5678, 0));
        t = mk(1, 0, DT_WORD, 32'h1000, 0, 5'd4, 0, 0, 5);
        t.rst_in_rd = 1;
        script.push_back(t);
        t = mk(1, 0, DT_WORD, 32'h1002, 0, 5'd6, 0, 0, 1);
        t.lit_addr_v = 1; t.lit_addr = 32'h1000; t.lit_wb_v = 1; t.lit_wb = 32'h80FF_1234;
        script.push_back(t);
        script.push_back(mk(1, 1, DT_HALF, 32'h2002, 0, 5'd10, 0, 0, 0));
        n_rand_left = 400;

        cyc = 0;
        while ((script.size() > 0 || n_rand_left > 0 || m_req || m_cool) && cyc < 20000) begin
            drive();
            model_edge();
            @(negedge clk);
            check();
            cyc++;
        end
        if (cyc >= 20000) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d cycles used, required under 20000", cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
